etc_frame_packer: RTL and testbench

//  Sits between non_stop_ETC and the UART TX FIFO. Converts each completed measurement (done pulse) into an ASCII frame.

---
 rtl/etc_frame_packer_pkg.sv | 28 ++
 rtl/etc_frame_packer_if.sv | 9 +
 rtl/etc_frame_packer_bin2bcd_seq.sv | 52 +++++
 rtl/etc_frame_packer.sv | 111 +++++++++++
 tb/tb_etc_frame_packer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/etc_frame_packer_pkg.sv
// Shared constants for the ETC frame packer: ASCII codes, FSM states, frame length.
// FRAME_LEN is 14 when ETC_FRAME_CHECKSUM_EN is defined, 11 otherwise.
package etc_frame_pkg;

    localparam logic [7:0] ASC_S     = 8'h53;
    localparam logic [7:0] ASC_COMMA = 8'h2C;
    localparam logic [7:0] ASC_E     = 8'h45;
    localparam logic [7:0] ASC_STAR  = 8'h2A;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_A     = 8'h41;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

`ifdef ETC_FRAME_CHECKSUM_EN
    localparam int FRAME_LEN = 14;
`else
    localparam int FRAME_LEN = 11;
`endif

    function automatic logic [7:0] hex2ascii(input logic [3:0] nibble);
        return (nibble < 4'd10) ? ASC_0 + {4'd0, nibble} : ASC_A + {4'd0, nibble} - 8'd10;
    endfunction

endpackage

// File: rtl/etc_frame_packer_if.sv
// Byte-push link from the frame packer into the UART TX FIFO.
interface etc_frame_packer_if #(parameter int DATA_SIZE = 8);
    logic                 write;
    logic [DATA_SIZE-1:0] data;
    logic                 fifo_full;

    modport master (output write, output data, input fifo_full);
    modport slave  (input write, input data, output fifo_full);
endinterface

// File: rtl/etc_frame_packer_bin2bcd_seq.sv
// Sequential double-dabble: one bit per cycle, WIDTH_SPEED steps in total,
// the first step taken on the start edge itself.
module bin2bcd_seq #(
    parameter int WIDTH_SPEED = 14
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [WIDTH_SPEED-1:0] bin,
    output logic                   busy,
    output logic [19:0]            bcd
);

    logic [WIDTH_SPEED-1:0] r_bin;
    logic [19:0]            r_bcd;
    logic [4:0]             r_cnt;
    logic [15:0]            w_adj_lo;

    function automatic logic [15:0] add3(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++)
            if (v[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
        return r;
    endfunction

    // Before the final shift the value is at most 32767, so the top digit never needs the +3.
    assign w_adj_lo = add3(r_bcd[15:0]);

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_cnt <= 5'd0;
        else if (start)
            r_cnt <= 5'(WIDTH_SPEED - 1);
        else if (r_cnt != 5'd0)
            r_cnt <= r_cnt - 5'd1;
    end

    always_ff @(posedge clk) begin
        if (start) begin
            r_bcd <= {19'd0, bin[WIDTH_SPEED-1]};
            r_bin <= bin << 1;
        end else if (r_cnt != 5'd0) begin
            r_bcd <= {r_bcd[18:16], w_adj_lo, r_bin[WIDTH_SPEED-1]};
            r_bin <= r_bin << 1;
        end
    end

    assign busy = (r_cnt != 5'd0);
    assign bcd  = r_bcd;

endmodule

// File: rtl/etc_frame_packer.sv
// Packs each accepted measurement into "S ddddd ,E e CR LF" and pushes it into the TX FIFO.
// ETC_FRAME_CHECKSUM_EN adds "*HL" (XOR of 'S'..e in uppercase hex) before CR.
module etc_frame_packer
    import etc_frame_pkg::*;
#(
    parameter int WIDTH_SPEED = 14,
    parameter int DATA_SIZE   = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   done,
    input  logic [WIDTH_SPEED-1:0] speed,
    input  logic [1:0]             valid_Epass,
    etc_frame_packer_if.master     fifo,
    output logic                   busy,
    output logic [7:0]             drop_cnt
);

    logic [1:0]  r_state;
    logic [3:0]  r_idx;
    logic [1:0]  r_epass;
    logic [7:0]  r_drop;
    logic        w_start;
    logic        w_write;
    logic        w_last;
    logic        w_conv_busy;
    logic [19:0] w_bcd;
    logic [7:0]  w_byte;
`ifdef ETC_FRAME_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    assign w_start = (r_state == ST_IDLE) && done;
    assign w_write = (r_state == ST_SEND) && !fifo.fifo_full;
    assign w_last  = (r_idx == 4'(FRAME_LEN - 1));

    bin2bcd_seq #(.WIDTH_SPEED(WIDTH_SPEED)) u_bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (w_start),
        .bin     (speed),
        .busy    (w_conv_busy),
        .bcd     (w_bcd)
    );

    always_comb begin
        w_byte = 8'd0;
        case (r_idx)
            4'd0:    w_byte = ASC_S;
            4'd1:    w_byte = ASC_0 + {4'd0, w_bcd[19:16]};
            4'd2:    w_byte = ASC_0 + {4'd0, w_bcd[15:12]};
            4'd3:    w_byte = ASC_0 + {4'd0, w_bcd[11:8]};
            4'd4:    w_byte = ASC_0 + {4'd0, w_bcd[7:4]};
            4'd5:    w_byte = ASC_0 + {4'd0, w_bcd[3:0]};
            4'd6:    w_byte = ASC_COMMA;
            4'd7:    w_byte = ASC_E;
            4'd8:    w_byte = ASC_0 + {6'd0, r_epass};
`ifdef ETC_FRAME_CHECKSUM_EN
            4'd9:    w_byte = ASC_STAR;
            4'd10:   w_byte = hex2ascii(r_csum[7:4]);
            4'd11:   w_byte = hex2ascii(r_csum[3:0]);
            4'd12:   w_byte = ASC_CR;
            4'd13:   w_byte = ASC_LF;
`else
            4'd9:    w_byte = ASC_CR;
            4'd10:   w_byte = ASC_LF;
`endif
            default: w_byte = 8'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_idx   <= 4'd0;
            r_drop  <= 8'd0;
        end else begin
            // Any done outside IDLE is lost, including the edge that returns to IDLE.
            if (done && (r_state != ST_IDLE) && (r_drop != 8'hFF))
                r_drop <= r_drop + 8'd1;
            case (r_state)
                ST_IDLE: if (done) r_state <= ST_CONV;
                ST_CONV: if (!w_conv_busy) begin
                    r_state <= ST_SEND;
                    r_idx   <= 4'd0;
                end
                ST_SEND: if (w_write) begin
                    r_idx <= r_idx + 4'd1;
                    if (w_last) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_start) r_epass <= valid_Epass;
`ifdef ETC_FRAME_CHECKSUM_EN
        if (w_start)
            r_csum <= 8'd0;
        else if (w_write && (r_idx < 4'd9))
            r_csum <= r_csum ^ w_byte;
`endif
    end

    assign fifo.write = w_write;
    assign fifo.data  = (r_state == ST_SEND) ? w_byte : 8'd0;
    assign busy       = (r_state != ST_IDLE);
    assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_etc_frame_packer.sv
// Self-checking bench for etc_frame_packer against a string-level frame model.
// Honours ETC_FRAME_CHECKSUM_EN for the expected frame layout.
module tb_etc_frame_packer;

    localparam int W = 14;
`ifdef ETC_FRAME_CHECKSUM_EN
    localparam int FL = 14;
`else
    localparam int FL = 11;
`endif

    typedef logic [7:0] byte_q_t [$];

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         done = 1'b0;
    logic [W-1:0] speed = '0;
    logic [1:0]   valid_Epass = 2'd0;
    logic         busy;
    logic [7:0]   drop_cnt;

    int      n_tests = 0;
    int      n_fail = 0;
    int      full_mode = 0;
    byte_q_t cap;
    int      viol = 0;

    etc_frame_packer_if #(.DATA_SIZE(8)) fifo_if();

    etc_frame_packer #(.WIDTH_SPEED(W), .DATA_SIZE(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .done        (done),
        .speed       (speed),
        .valid_Epass (valid_Epass),
        .fifo        (fifo_if),
        .busy        (busy),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        case (full_mode)
            0:       fifo_if.fifo_full = 1'b0;
            1:       fifo_if.fifo_full = ~fifo_if.fifo_full;
            default: fifo_if.fifo_full = ($urandom_range(0, 2) == 0);
        endcase
    end

    // FIFO side: record every pushed byte and any push attempted while full.
    always @(negedge clk) begin
        if (fifo_if.write === 1'b1) begin
            cap.push_back(fifo_if.data);
            if (fifo_if.fifo_full !== 1'b0) viol++;
        end
    end

    function automatic byte_q_t model_frame(input int sp, input int ep);
        byte_q_t q;
`ifdef ETC_FRAME_CHECKSUM_EN
        logic [7:0] x;
        string      s;
`endif
        q.push_back(8'h53);
        for (int p = 10000; p >= 1; p = p / 10)
            q.push_back(8'(48 + (sp / p) % 10));
        q.push_back(8'h2C);
        q.push_back(8'h45);
        q.push_back(8'(48 + ep));
`ifdef ETC_FRAME_CHECKSUM_EN
        x = 8'd0;
        foreach (q[i]) x = x ^ q[i];
        s = $sformatf("%02X", x);
        q.push_back(8'h2A);
        q.push_back(8'(s[0]));
        q.push_back(8'(s[1]));
`endif
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        return q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input int base, input byte_q_t exp, input string name);
        int got;
        int bad_i;
        got = cap.size() - base;
        bad_i = -1;
        foreach (exp[i])
            if (bad_i < 0 && (base + i >= cap.size() || cap[base + i] !== exp[i])) bad_i = i;
        n_tests++;
        if (got != exp.size() || bad_i >= 0) begin
            n_fail++;
            if (bad_i >= 0 && base + bad_i < cap.size())
                $display("FAIL %s frame: %0d bytes, byte %0d = %02h, required %0d bytes, byte %0d = %02h",
                         name, got, bad_i, cap[base + bad_i], exp.size(), bad_i, exp[bad_i]);
            else
                $display("FAIL %s frame: %0d bytes, required %0d bytes", name, got, exp.size());
        end
    endtask

    task automatic run_frame(input logic [W-1:0] sp, input logic [1:0] ep, input string name,
                             input bit chk_timing);
        byte_q_t exp;
        int base, v0, cyc, first;
        exp = model_frame(int'(sp), int'(ep));
        base = cap.size();
        v0 = viol;
        first = -1;
        speed = sp; valid_Epass = ep; done = 1'b1;
        tick();
        done = 1'b0;
        speed = W'($urandom); valid_Epass = 2'($urandom);
        cyc = 0;
        while (busy === 1'b1 && cyc < 2000) begin
            cyc++;
            tick();
            if (fifo_if.write === 1'b1 && first < 0) first = cyc;
        end
        n_tests++;
        if (cyc >= 2000) begin n_fail++; $display("FAIL %s timeout: busy still %b", name, busy); end
        check_frame(base, exp, name);
        n_tests++;
        if (viol != v0) begin n_fail++; $display("FAIL %s write-while-full: %0d, required 0", name, viol - v0); end
        if (chk_timing) begin
            n_tests++;
            if (first != W) begin n_fail++; $display("FAIL %s latency: %0d, required %0d", name, first, W); end
            n_tests++;
            if (cyc != W + FL) begin n_fail++; $display("FAIL %s busy cycles: %0d, required %0d", name, cyc, W + FL); end
        end
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while (busy !== 1'b0 && cyc < 2000) begin cyc++; tick(); end
        n_tests++;
        if (cyc >= 2000) begin n_fail++; $display("FAIL %s idle timeout: busy %b, required 0", name, busy); end
    endtask

    task automatic test_reset();
        full_mode = 0;
        reset_n = 1'b0;
        repeat (3) tick();
        n_tests++; if (fifo_if.write !== 1'b0) begin n_fail++; $display("FAIL reset write: %b, required 0", fifo_if.write); end
        n_tests++; if (fifo_if.data !== 8'd0) begin n_fail++; $display("FAIL reset data: %02h, required 00", fifo_if.data); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: %b, required 0", busy); end
        n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset drop_cnt: %0d, required 0", drop_cnt); end
        reset_n = 1'b1;
        repeat (2) tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle busy: %b, required 0", busy); end
    endtask

    task automatic test_basic();
        run_frame(W'(1234), 2'd1, "basic_1234", 1'b1);
    endtask

    task automatic test_digits();
        run_frame(W'(0), 2'd3, "zero", 1'b1);
        run_frame(W'(16383), 2'($urandom), "max", 1'b1);
        full_mode = 2;
        for (int i = 0; i < 12; i++) run_frame(W'($urandom), 2'($urandom), "random", 1'b0);
        full_mode = 0;
        tick();
    endtask

    task automatic test_backpressure();
        full_mode = 1;
        run_frame(W'(1234), 2'd1, "toggle_full", 1'b0);
        full_mode = 0;
        tick();
    endtask

    task automatic test_drops();
        byte_q_t exp;
        int base;
        exp = model_frame(4321, 2);
        base = cap.size();
        speed = W'(4321); valid_Epass = 2'd2; done = 1'b1;
        tick(); done = 1'b0;
        repeat (2) tick();
        speed = W'(99); done = 1'b1; tick(); done = 1'b0;
        tick();
        done = 1'b1; tick(); done = 1'b0;
        repeat (W) tick();
        done = 1'b1; tick(); done = 1'b0;
        wait_idle("drops");
        check_frame(base, exp, "drops");
        n_tests++; if (drop_cnt !== 8'd3) begin n_fail++; $display("FAIL drop_cnt three: %0d, required 3", drop_cnt); end
        done = 1'b1;
        repeat (420) tick();
        done = 1'b0;
        wait_idle("saturate");
        n_tests++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL drop_cnt saturate: %0d, required 255", drop_cnt); end
    endtask

    task automatic test_reset_mid();
        int base, cyc, n;
        base = cap.size();
        speed = W'(1234); valid_Epass = 2'd1; done = 1'b1;
        tick(); done = 1'b0;
        cyc = 0;
        while (cap.size() - base < 5 && cyc < 200) begin cyc++; tick(); end
        n_tests++; if (cyc >= 200) begin n_fail++; $display("FAIL midreset reach byte 5: %0d bytes, required 5", cap.size() - base); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n = cap.size();
        n_tests++; if (fifo_if.write !== 1'b0) begin n_fail++; $display("FAIL midreset write: %b, required 0", fifo_if.write); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset busy: %b, required 0", busy); end
        n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL midreset drop_cnt: %0d, required 0", drop_cnt); end
        repeat (30) tick();
        n_tests++; if (cap.size() != n) begin n_fail++; $display("FAIL midreset stray bytes: %0d, required 0", cap.size() - n); end
        run_frame(W'($urandom), 2'($urandom), "after_reset", 1'b1);
    endtask

    task automatic test_idle_return();
        byte_q_t exp;
        int base, cyc;
        exp = model_frame(777, 0);
        base = cap.size();
        speed = W'(777); valid_Epass = 2'd0; done = 1'b1;
        tick(); done = 1'b0;
        cyc = 0;
        while (!(fifo_if.write === 1'b1 && cap.size() - base == FL - 1) && cyc < 200) begin cyc++; tick(); end
        n_tests++; if (cyc >= 200) begin n_fail++; $display("FAIL return reach last byte: %0d bytes, required %0d", cap.size() - base, FL - 1); end
        done = 1'b1;
        tick();
        done = 1'b0;
        check_frame(base, exp, "return_frame");
        n_tests++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL return drop_cnt: %0d, required 1", drop_cnt); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL return busy: %b, required 0", busy); end
        run_frame(W'($urandom), 2'($urandom), "next_cycle_accept", 1'b1);
        n_tests++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL accept drop_cnt: %0d, required 1", drop_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_digits();
        test_backpressure();
        test_drops();
        test_reset_mid();
        test_idle_return();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
